mac_seq_ctrl: RTL

- Sequential controller for an unsigned radix-4 multiply-accumulate datapath.
- Accepts a stream of `len` (A, X) operand pairs over a valid/ready handshake.
- Multiplies each pair 2 multiplier bits per cycle using one shared mux-shift-add stage, then accumulates into a dot-product register.
- Sits between the operand source and result consumer in the MAC tile; replaces the fully unrolled multiplier tree where area matters more than throughput.

---
 rtl/mac_seq_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/mac_seq_ctrl.sv
// Radix-4 shift-add multiply-accumulate controller: dot product of len (A, X) pairs, 2 multiplier bits per cycle.
// Latency 1 + len*(M/2+2) cycles with no input stalls; in_ready only in LOAD, result held in DONE until out_ready.
module mac_seq_ctrl #(
    parameter int N     = 8,
    parameter int M     = 8,
    parameter int CNT_W = 8,
    parameter int ACC_W = N + M + 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     A,
    input  logic [M-1:0]     X,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] ACC
);

    localparam int HALF   = M / 2;
    localparam int STEP_W = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(HALF - 1);

    typedef enum logic [2:0] {IDLE, LOAD, MULT, ACCUM, DONE} state_t;

    state_t             state, next_state;
    logic [N-1:0]       a_r;
    logic [M-1:0]       x_r;
    logic [N+M-1:0]     partial;
    logic [STEP_W-1:0]  step;
    logic [CNT_W-1:0]   remaining;
    logic [N+M-1:0]     pp_lo, pp_hi, pp_step;

    assign in_ready = (state == LOAD);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = (len == '0) ? DONE : LOAD;
            LOAD:  if (in_valid) next_state = MULT;
            MULT:  if (step == LAST_STEP) next_state = ACCUM;
            // remaining is never zero here, so "new remaining == 0" is remaining == 1
            ACCUM: next_state = (remaining == CNT_W'(1)) ? DONE : LOAD;
            DONE:  if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One radix-4 digit: A*x[1:0] weighted by 4^step
    always_comb begin
        pp_lo   = (N+M)'(a_r & {N{x_r[0]}});
        pp_hi   = (N+M)'(a_r & {N{x_r[1]}}) << 1;
        pp_step = (pp_lo + pp_hi) << {step, 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            ACC       <= '0;
            a_r       <= '0;
            x_r       <= '0;
            partial   <= '0;
            step      <= '0;
            remaining <= '0;
        end else begin
            state     <= next_state;
            busy      <= (next_state != IDLE);
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        ACC       <= '0;
                        remaining <= len;
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        a_r     <= A;
                        x_r     <= X;
                        partial <= '0;
                        step    <= '0;
                    end
                end
                MULT: begin
                    partial <= partial + pp_step;
                    x_r     <= x_r >> 2;
                    step    <= step + STEP_W'(1);
                end
                ACCUM: begin
                    ACC       <= ACC + ACC_W'(partial);
                    remaining <= remaining - CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
